// File: rtl/nn_udiv_43ns_4ns_39_seq_if.sv
// Start/done request bundle for the sequential unsigned divider.
// The requester holds the master modport, the divider the slave modport.
interface nn_udiv_43ns_4ns_39_seq_if #(
   parameter int din0_WIDTH = 43,
   parameter int din1_WIDTH = 4,
   parameter int dout_WIDTH = 39
);
   logic                  ap_start;
   logic [din0_WIDTH-1:0] din0;
   logic [din1_WIDTH-1:0] din1;
   logic                  ap_idle;
   logic                  ap_done;
   logic [dout_WIDTH-1:0] dout;
   logic [din1_WIDTH-1:0] rem;
   logic                  dz;
   logic                  ovf;

   modport master (
      output ap_start, din0, din1,
      input  ap_idle, ap_done, dout, rem, dz, ovf
   );

   modport slave (
      input  ap_start, din0, din1,
      output ap_idle, ap_done, dout, rem, dz, ovf
   );
endinterface

// File: rtl/nn_udiv_43ns_4ns_39_seq.sv
// Restoring unsigned divider, 43b / 4b -> 39b quotient + 4b remainder, fixed latency.
// Define NN_UDIV_RADIX4_EN to retire two quotient bits per CALC cycle instead of one.
module nn_udiv_43ns_4ns_39_seq #(
   parameter int ID         = 1,
   parameter int din0_WIDTH = 43,
   parameter int din1_WIDTH = 4,
   parameter int dout_WIDTH = 39
) (
   input  logic ap_clk,
   input  logic ap_rst,
   nn_udiv_43ns_4ns_39_seq_if.slave bus
);
`ifdef NN_UDIV_RADIX4_EN
   localparam int STEP = 2;
`else
   localparam int STEP = 1;
`endif
   localparam int ITERS = (din0_WIDTH + STEP - 1) / STEP;
   localparam int EXT_W = ITERS * STEP;
   localparam int CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;
   localparam int PR_W  = din1_WIDTH + 1;
   localparam int HI_W  = din0_WIDTH - dout_WIDTH;
   localparam int CMP_W = (HI_W > din1_WIDTH) ? HI_W : din1_WIDTH;

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [EXT_W-1:0]      dvd_q, dvd_d;
   logic [din1_WIDTH-1:0] dvs_q, dvs_d;
   logic [PR_W-1:0]       pr_q, pr_d;
   logic [EXT_W-1:0]      quo_q, quo_d;
   logic                  dz_flag_q, dz_flag_d;
   logic                  ovf_flag_q, ovf_flag_d;
   logic                  idle_q, idle_d;
   logic                  done_q, done_d;
   logic [dout_WIDTH-1:0] dout_q, dout_d;
   logic [din1_WIDTH-1:0] rem_q, rem_d;
   logic                  dz_q, dz_d;
   logic                  ovf_q, ovf_d;

   logic [PR_W-1:0]       pr_step;
   logic [PR_W-1:0]       shifted;
   logic [STEP-1:0]       q_bits;
   logic [EXT_W-1:0]      quo_step;

   // Cascaded restoring stages; the remainder never reaches the divisor, so the shift drops a zero MSB.
   always_comb begin
      pr_step = pr_q;
      shifted = '0;
      q_bits  = '0;
      for (int i = 0; i < STEP; i++) begin
         shifted = PR_W'({pr_step, dvd_q[EXT_W-1-i]});
         if (shifted >= {1'b0, dvs_q}) begin
            pr_step             = shifted - {1'b0, dvs_q};
            q_bits[STEP-1-i]    = 1'b1;
         end else begin
            pr_step = shifted;
         end
      end
      quo_step = (quo_q << STEP) | EXT_W'(q_bits);
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      dvd_d      = dvd_q;
      dvs_d      = dvs_q;
      pr_d       = pr_q;
      quo_d      = quo_q;
      dz_flag_d  = dz_flag_q;
      ovf_flag_d = ovf_flag_q;
      idle_d     = idle_q;
      done_d     = 1'b0;
      dout_d     = dout_q;
      rem_d      = rem_q;
      dz_d       = dz_q;
      ovf_d      = ovf_q;
      case (state_q)
         S_IDLE: begin
            if (bus.ap_start) begin
               dvd_d      = EXT_W'(bus.din0);
               dvs_d      = bus.din1;
               pr_d       = '0;
               quo_d      = '0;
               cnt_d      = CNT_W'(ITERS - 1);
               dz_flag_d  = (bus.din1 == '0);
               // Quotient fits in dout_WIDTH bits iff the dividend's top part is below the divisor.
               ovf_flag_d = (bus.din1 != '0) &&
                            (CMP_W'(bus.din0[din0_WIDTH-1:dout_WIDTH]) >= CMP_W'(bus.din1));
               idle_d     = 1'b0;
               state_d    = S_CALC;
            end
         end
         S_CALC: begin
            pr_d  = pr_step;
            quo_d = quo_step;
            dvd_d = dvd_q << STEP;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == '0) begin
               state_d = S_DONE;
               done_d  = 1'b1;
               dz_d    = dz_flag_q;
               ovf_d   = ovf_flag_q;
               if (dz_flag_q || ovf_flag_q) begin
                  dout_d = '1;
                  rem_d  = '0;
               end else begin
                  dout_d = quo_step[dout_WIDTH-1:0];
                  rem_d  = pr_step[din1_WIDTH-1:0];
               end
            end
         end
         S_DONE: begin
            idle_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            idle_d  = 1'b1;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         dvd_q      <= '0;
         dvs_q      <= '0;
         pr_q       <= '0;
         quo_q      <= '0;
         dz_flag_q  <= 1'b0;
         ovf_flag_q <= 1'b0;
         idle_q     <= 1'b1;
         done_q     <= 1'b0;
         dout_q     <= '0;
         rem_q      <= '0;
         dz_q       <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         dvd_q      <= dvd_d;
         dvs_q      <= dvs_d;
         pr_q       <= pr_d;
         quo_q      <= quo_d;
         dz_flag_q  <= dz_flag_d;
         ovf_flag_q <= ovf_flag_d;
         idle_q     <= idle_d;
         done_q     <= done_d;
         dout_q     <= dout_d;
         rem_q      <= rem_d;
         dz_q       <= dz_d;
         ovf_q      <= ovf_d;
      end
   end

   assign bus.ap_idle = idle_q;
   assign bus.ap_done = done_q;
   assign bus.dout    = dout_q;
   assign bus.rem     = rem_q;
   assign bus.dz      = dz_q;
   assign bus.ovf     = ovf_q;
endmodule

// File: tb/tb_nn_udiv_43ns_4ns_39_seq.sv
// Directed bench for nn_udiv_43ns_4ns_39_seq: hand-computed quotients, flags, latency,
// ignored starts and mid-operation reset.
module tb_nn_udiv_43ns_4ns_39_seq;
   localparam int W0 = 43;
   localparam int W1 = 4;
   localparam int WQ = 39;
`ifdef NN_UDIV_RADIX4_EN
   localparam int LAT = 23;
`else
   localparam int LAT = 44;
`endif
   localparam logic [63:0] ONES = 64'h7F_FFFF_FFFF;

   logic ap_clk = 1'b0;
   logic ap_rst = 1'b1;
   int   vectors = 0;
   int   miscompares = 0;

   always #5 ap_clk = ~ap_clk;

   nn_udiv_43ns_4ns_39_seq_if #(.din0_WIDTH(W0), .din1_WIDTH(W1), .dout_WIDTH(WQ)) bus ();

   nn_udiv_43ns_4ns_39_seq #(.ID(1), .din0_WIDTH(W0), .din1_WIDTH(W1), .dout_WIDTH(WQ)) dut (
      .ap_clk (ap_clk),
      .ap_rst (ap_rst),
      .bus    (bus)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge ap_clk);
      #1;
   endtask

   // Called just after a rising edge while idle; returns in cycle 1 with ap_start dropped.
   task automatic start_op(input logic [63:0] a, input logic [63:0] b);
      bus.ap_start = 1'b1;
      bus.din0     = a[W0-1:0];
      bus.din1     = b[W1-1:0];
      @(negedge ap_clk);
      chk("idle_at_accept", 64'(bus.ap_idle), 64'd1);
      next_cycle();
      bus.ap_start = 1'b0;
   endtask

   task automatic wait_done(output int lat);
      lat = -1;
      for (int cyc = 1; cyc <= 200; cyc++) begin
         @(negedge ap_clk);
         if (bus.ap_done === 1'b1) begin
            lat = cyc;
            break;
         end
         next_cycle();
      end
   endtask

   task automatic run(input string tag, input logic [63:0] a, input logic [63:0] b,
                      input logic [63:0] eq, input logic [63:0] er,
                      input logic edz, input logic eovf);
      int lat;
      start_op(a, b);
      wait_done(lat);
      chk({tag, ".latency"}, 64'(lat), 64'(LAT));
      chk({tag, ".dout"},    64'(bus.dout), eq);
      chk({tag, ".rem"},     64'(bus.rem),  er);
      chk({tag, ".dz"},      64'(bus.dz),   64'(edz));
      chk({tag, ".ovf"},     64'(bus.ovf),  64'(eovf));
      $display("op %s: din0=%0d din1=%0d -> dout=0x%0h rem=%0d dz=%0b ovf=%0b lat=%0d",
               tag, a, b, bus.dout, bus.rem, bus.dz, bus.ovf, lat);
      next_cycle();
      @(negedge ap_clk);
      chk({tag, ".idle_after"}, 64'(bus.ap_idle), 64'd1);
      chk({tag, ".done_after"}, 64'(bus.ap_done), 64'd0);
      next_cycle();
   endtask

   initial begin
      int early;
      int lat;
      bus.ap_start = 1'b0;
      bus.din0     = '0;
      bus.din1     = '0;
      repeat (3) @(posedge ap_clk);
      #1;
      ap_rst = 1'b0;
      @(negedge ap_clk);
      chk("rst.idle", 64'(bus.ap_idle), 64'd1);
      chk("rst.done", 64'(bus.ap_done), 64'd0);
      chk("rst.dout", 64'(bus.dout),    64'd0);
      chk("rst.rem",  64'(bus.rem),     64'd0);
      chk("rst.dz",   64'(bus.dz),      64'd0);
      chk("rst.ovf",  64'(bus.ovf),     64'd0);
      $display("reset state checked");
      next_cycle();

      run("small",       64'd100,           64'd7,  64'd14,           64'd2,  1'b0, 1'b0);
      run("mul_max",     64'd8246337208305, 64'd15, ONES,             64'd0,  1'b0, 1'b0);
      run("edge_no_ovf", 64'd8246337208319, 64'd15, ONES,             64'd14, 1'b0, 1'b0);
      run("edge_ovf",    64'd8246337208320, 64'd15, ONES,             64'd0,  1'b0, 1'b1);
      run("ovf_2p42",    64'h400_0000_0000, 64'd1,  ONES,             64'd0,  1'b0, 1'b1);
      run("ovf_all1",    64'h7FF_FFFF_FFFF, 64'd15, ONES,             64'd0,  1'b0, 1'b1);
      run("div_zero",    64'd123,           64'd0,  ONES,             64'd0,  1'b1, 1'b0);
      run("pow39_by2",   64'h80_0000_0000,  64'd2,  64'h40_0000_0000, 64'd0,  1'b0, 1'b0);
      run("pow39_by1",   64'h80_0000_0000,  64'd1,  ONES,             64'd0,  1'b0, 1'b1);
      run("mid",         64'd1234567,       64'd10, 64'd123456,       64'd7,  1'b0, 1'b0);
      run("lt_div",      64'd5,             64'd9,  64'd0,            64'd5,  1'b0, 1'b0);

      // Starts while busy and in the DONE cycle must be ignored.
      early = 0;
      start_op(64'd100, 64'd7);
      for (int c = 1; c <= LAT; c++) begin
         if (c > 1) next_cycle();
         bus.ap_start = (c == 5 || c == LAT);
         bus.din0     = 43'd50;
         bus.din1     = 4'd3;
         @(negedge ap_clk);
         if (c < LAT && bus.ap_done === 1'b1) early++;
      end
      chk("busy.early_done", 64'(early),       64'd0);
      chk("busy.done",       64'(bus.ap_done), 64'd1);
      chk("busy.dout",       64'(bus.dout),    64'd14);
      chk("busy.rem",        64'(bus.rem),     64'd2);
      $display("busy starts ignored: dout=%0d rem=%0d", bus.dout, bus.rem);
      next_cycle();
      start_op(64'd50, 64'd3);
      wait_done(lat);
      chk("next.latency", 64'(lat),      64'(LAT));
      chk("next.dout",    64'(bus.dout), 64'd16);
      chk("next.rem",     64'(bus.rem),  64'd2);
      $display("follow-on op 50/3 -> dout=%0d rem=%0d lat=%0d", bus.dout, bus.rem, lat);
      next_cycle();
      next_cycle();

      // Reset during CALC aborts the operation and clears the held results.
      start_op(64'd1000, 64'd9);
      repeat (19) next_cycle();
      @(negedge ap_clk);
      chk("abort.held_dout", 64'(bus.dout), 64'd16);
      ap_rst = 1'b1;
      next_cycle();
      ap_rst = 1'b0;
      @(negedge ap_clk);
      chk("abort.idle", 64'(bus.ap_idle), 64'd1);
      chk("abort.done", 64'(bus.ap_done), 64'd0);
      chk("abort.dout", 64'(bus.dout),    64'd0);
      chk("abort.rem",  64'(bus.rem),     64'd0);
      chk("abort.dz",   64'(bus.dz),      64'd0);
      chk("abort.ovf",  64'(bus.ovf),     64'd0);
      early = 0;
      for (int c = 22; c <= 60; c++) begin
         next_cycle();
         @(negedge ap_clk);
         if (bus.ap_done === 1'b1) early++;
      end
      chk("abort.no_done", 64'(early), 64'd0);
      $display("reset at cycle 20 aborted op; done pulses seen=%0d", early);
      next_cycle();

      run("after_abort", 64'd1000, 64'd9, 64'd111, 64'd1, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/nn_udiv_43ns_4ns_39_seq.md
Name: nn_udiv_43ns_4ns_39_seq

Overview:
- Sequential unsigned divider; the inverse of the 39x4->43 unsigned multiplier in the NN datapath.
- Takes a 43-bit dividend and a 4-bit divisor. Produces a 39-bit quotient and a 4-bit remainder.
- Restoring algorithm, one quotient bit per cycle.
- Used by the Alex_Net normalisation and averaging stages to undo scale products. Start/done handshake in ap_ style.

Parameters:
- ID, 1, instance tag; no functional effect.
- din0_WIDTH, 43, dividend width.
- din1_WIDTH, 4, divisor width; also the remainder width.
- dout_WIDTH, 39, quotient width. Requires din0_WIDTH > dout_WIDTH.

Ports:
- ap_clk  in  1  clock; all logic on rising edge.
- ap_rst  in  1  synchronous, active-high reset.
- ap_start  in  1  request; sampled only while ap_idle=1.
- din0  in  din0_WIDTH  unsigned dividend; captured on accept.
- din1  in  din1_WIDTH  unsigned divisor; captured on accept.
- ap_idle  out  1  high when a new operation can be accepted.
- ap_done  out  1  single-cycle pulse; results valid.
- dout  out  dout_WIDTH  quotient; held until the next ap_done.
- rem  out  din1_WIDTH  remainder; held until the next ap_done.
- dz  out  1  divide-by-zero flag; held with dout.
- ovf  out  1  quotient-overflow flag; held with dout.

Behaviour:
- Reset values: ap_idle=1, ap_done=0, dout=0, rem=0, dz=0, ovf=0, FSM=IDLE. Internal registers cleared.
- FSM states: IDLE, CALC, DONE.
  - IDLE: ap_idle=1. On ap_start=1, capture din0/din1, load partial remainder=0 and iteration counter=din0_WIDTH-1, then go to CALC. Accept cycle is cycle 0.
  - CALC: ap_idle=0. Per cycle: shift the next dividend bit (MSB first) into the partial remainder (din1_WIDTH+1 bits). Trial-subtract the divisor; if non-negative, keep the difference and shift in quotient bit 1, else restore and shift in 0. When the counter reaches 0, go to DONE.
  - DONE: register results, ap_done=1 for exactly one cycle, ap_idle=0, then return to IDLE.
- Latency: ap_done asserts at cycle din0_WIDTH+1 after accept (44 at defaults). Latency is fixed and data-independent, including the dz and ovf cases.
- Internal quotient register is din0_WIDTH wide. dout = its low dout_WIDTH bits, unless a flag overrides.
- Overflow (evaluated at accept): ovf=1 iff din1≠0 and din0[din0_WIDTH-1:dout_WIDTH] >= din1. On overflow, dout saturates to all ones and rem=0.
- Divide by zero: din1=0 gives dz=1, ovf=0, dout all ones, rem=0.
- Any product of the companion multiplier (din0 <= (2^39-1)*din1, din1≠0) yields exact q, r=0, ovf=0.
- ap_start while ap_idle=0: ignored; captured operands are unaffected.
- ap_start high in the DONE cycle: not accepted. The earliest next accept is the following IDLE cycle, so back-to-back throughput is one result per din0_WIDTH+2 cycles.
- ap_rst at any cycle, including mid-CALC: the next cycle is reset state, the operation is aborted, and no ap_done is produced.
- Outputs change only in the DONE cycle.

Optional Feature:
- Macro NN_UDIV_RADIX4_EN.
- Defined: two quotient bits per CALC cycle, via two cascaded trial subtractions. Iterations = ceil(din0_WIDTH/2); the odd top bit is padded with a zero. Latency is ceil(din0_WIDTH/2)+1 (23 at defaults). Results, flags and handshake are identical.
- Undefined: radix-2 as described above, latency din0_WIDTH+1.

Test Plan:
- din0=100, din1=7, ap_start for one cycle -> cycle 44: ap_done=1, dout=14, rem=2, dz=0, ovf=0. ap_idle=1 at cycle 45.
- din0=8246337208305 ((2^39-1)*15), din1=15 -> dout=0x7FFFFFFFFF, rem=0, ovf=0.
- din0=2^42, din1=1 -> ovf=1, dout=0x7FFFFFFFFF, rem=0, done at cycle 44. Also din0=123, din1=0 -> dz=1, dout all ones, rem=0, done at cycle 44.
- Accept 100/7, then ap_start with 50/3 at cycles 5 and 44 -> both ignored; single ap_done with 14/2. The next start, at cycle 45, yields 16/2 at cycle 89.
- Accept 1000/9, assert ap_rst at cycle 20 -> cycle 21: ap_idle=1, all outputs 0, no ap_done through cycle 60.
- With NN_UDIV_RADIX4_EN defined, repeat the first two scenarios -> identical dout/rem, ap_done at cycle 23.
